gate_driver_fault_monitor: RTL and testbench
============================================

GATE_DRIVER_FAULT_MONITOR -- requirements
Module: gate_driver_fault_monitor

Interface
REQ-001 Parameter clk_freq_hz, default 54_000_000, is the system clock frequency in Hz.
REQ-002 Parameter debounce_us, default 2, is the time fault_n must stay low before a fault is accepted.
REQ-003 Parameter recover_us, default 50, is the settle time after a reset before fault_n is rechecked.
REQ-004 Parameter max_fast_retries, default 3, is the number of fast resets tried before escalating to one slow reset.
REQ-005 sys_clk  input  1  system clock; all logic on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 fault_n  input  1  driver nFAULT pin, asynchronous, active low.
REQ-008 enable_req  input  1  controller request to enable the gate driver.
REQ-009 clear_fault  input  1  single-cycle pulse that releases the LOCKOUT state.
REQ-010 reset_done  input  1  done flag from gate_driver_reset; high when that reset has finished.
REQ-011 driver_enable  output  1  enable level driven to gate_driver_reset driver_enable.
REQ-012 reset_start  output  1  single-cycle reset request to gate_driver_reset.
REQ-013 slow_reset  output  1  reset-type select; 1 selects a slow reset, 0 a fast reset.
REQ-014 fault_active  output  1  high in every state from DEBOUNCE-confirmed onward until RUN resumes.
REQ-015 lockout  output  1  high in the LOCKOUT state only.
REQ-016 retry_cnt  output  3  number of fast resets issued in the current fault episode.

Function
REQ-017 fault_n shall pass through a 2-flop synchronizer; all logic uses only the synchronized value flt.
REQ-018 Tick constants: ticks_per_us = clk_freq_hz/1e6, debounce_ticks = ticks_per_us*debounce_us, recover_ticks = ticks_per_us*recover_us, done_timeout_ticks = ticks_per_us*100.
REQ-019 FSM states: IDLE, RUN, DEBOUNCE, ISSUE, WAIT_DONE, RECOVER, LOCKOUT.
REQ-020 IDLE: driver_enable=0; go to RUN when enable_req=1.
REQ-021 RUN: driver_enable=1; go to IDLE if enable_req=0 (takes priority over a fault); go to DEBOUNCE with counter cleared if flt=0.
REQ-022 DEBOUNCE: increment the counter while flt=0; return to RUN when flt=1 (glitch); go to ISSUE when the counter reaches debounce_ticks-1.
REQ-023 ISSUE (one cycle): reset_start=1; slow_reset = (retry_cnt==max_fast_retries); increment retry_cnt only if the reset is fast; next state WAIT_DONE.
REQ-024 WAIT_DONE: driver_enable=1; go to RECOVER when reset_done=1; go to LOCKOUT if done_timeout_ticks elapse without reset_done.
REQ-025 RECOVER: wait recover_ticks, then check flt.
REQ-026 RECOVER result, flt=1: clear retry_cnt and go to RUN.
REQ-027 RECOVER result, flt=0 with retry_cnt<max_fast_retries: go to ISSUE for another fast reset.
REQ-028 RECOVER result, flt=0 with retry_cnt==max_fast_retries and the slow reset not yet done: go to ISSUE for the slow reset.
REQ-029 RECOVER result, flt=0 after the slow reset: go to LOCKOUT.
REQ-030 LOCKOUT: driver_enable=0; leave only on clear_fault=1 with enable_req=0, going to IDLE and clearing retry_cnt; clear_fault is ignored while enable_req=1.
REQ-031 enable_req=0 in DEBOUNCE, ISSUE, WAIT_DONE or RECOVER: finish the current WAIT_DONE, then go to IDLE; in the other three states go to IDLE at once.
REQ-032 All counters are wide enough for done_timeout_ticks and never wrap; retry_cnt saturates at max_fast_retries.
REQ-033 reset_start shall never be high for two consecutive cycles.

Reset
REQ-034 While reset_n=0: state=IDLE, all outputs 0, retry_cnt=0, counters 0, synchronizer flops=1 (no fault).

Configuration
REQ-035 Macro GATE_DRIVER_FAULT_STATS_EN adds output fault_events [15:0], a saturating count of confirmed faults (DEBOUNCE->ISSUE), reset only by reset_n.
REQ-036 Without GATE_DRIVER_FAULT_STATS_EN the port and its counter are absent, and all other behaviour is identical.

Structure
REQ-037 The state enum and tick-calculation functions shall live in package bldc_gate_pkg.
REQ-038 The synchronizer and debounce logic shall be sub-module fault_debounce, with output flt and a confirmed pulse.

Verification
REQ-039 Reset, then enable_req=1 -> driver_enable=1 one cycle later; reset_start stays 0.
REQ-040 fault_n low for 60 cycles (below 108) -> no reset_start, state returns to RUN.
REQ-041 fault_n low for 200 cycles, reset_done returned 270 cycles after reset_start, fault_n high -> exactly one fast reset_start, retry_cnt=1 then 0, back in RUN.
REQ-042 fault_n held low permanently -> 3 fast pulses (slow_reset=0), then 1 slow pulse (slow_reset=1), then lockout=1 and driver_enable=0; clear_fault while enable_req=1 is ignored, with enable_req=0 the block goes to IDLE.
REQ-043 reset_done never returned -> lockout=1 exactly 5400 cycles after WAIT_DONE entry.
REQ-044 With GATE_DRIVER_FAULT_STATS_EN: 2 confirmed faults -> fault_events=2; a reset_n pulse mid-WAIT_DONE -> all outputs 0 and fault_events=0.

Source files
------------

// File: rtl/bldc_gate_pkg.sv
// Shared FSM state type and tick-conversion helpers for the gate driver fault monitor.
package bldc_gate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RECOVER   = 3'd5,
    ST_LOCKOUT   = 3'd6
  } state_t;

  localparam int DONE_TIMEOUT_US = 100;

  function automatic int ticks_per_us(input int clk_freq_hz);
    return clk_freq_hz / 1_000_000;
  endfunction

  // Clamp to one tick so a slow clock never yields a zero-length interval.
  function automatic int us_to_ticks(input int clk_freq_hz, input int us);
    int t;
    t = ticks_per_us(clk_freq_hz) * us;
    return (t < 1) ? 1 : t;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fault_debounce.sv
// nFAULT 2-flop synchronizer plus low-time qualifier; confirmed fires when the
// synchronized fault has been low for DEBOUNCE_TICKS consecutive armed cycles.
module fault_debounce
  import bldc_gate_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 108
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic fault_n,
  input  logic arm,
  output logic flt,
  output logic confirmed
);

  localparam int CW = max_int($clog2(DEBOUNCE_TICKS + 1), 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;

  // Flops come out of reset at 1 so a missing driver does not look like a fault.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], fault_n};
    end
  end

  assign flt = r_sync[1];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!arm) begin
      r_cnt <= '0;
    end else if (!flt && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign confirmed = arm && !flt && (r_cnt == CNT_LAST);

endmodule

// File: rtl/gate_driver_fault_monitor.sv
// Gate driver nFAULT supervisor: debounce, fast/slow reset retries, lockout.
// Optional macro GATE_DRIVER_FAULT_STATS_EN adds the fault_events counter port.
module gate_driver_fault_monitor
  import bldc_gate_pkg::*;
#(
  parameter int clk_freq_hz      = 54_000_000,
  parameter int debounce_us      = 2,
  parameter int recover_us       = 50,
  parameter int max_fast_retries = 3
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       fault_n,
  input  logic       enable_req,
  input  logic       clear_fault,
  input  logic       reset_done,
  output logic       driver_enable,
  output logic       reset_start,
  output logic       slow_reset,
  output logic       fault_active,
  output logic       lockout,
  output logic [2:0] retry_cnt
`ifdef GATE_DRIVER_FAULT_STATS_EN
  ,
  output logic [15:0] fault_events
`endif
);

  localparam int DEBOUNCE_TICKS     = us_to_ticks(clk_freq_hz, debounce_us);
  localparam int RECOVER_TICKS      = us_to_ticks(clk_freq_hz, recover_us);
  localparam int DONE_TIMEOUT_TICKS = us_to_ticks(clk_freq_hz, DONE_TIMEOUT_US);
  localparam int TIMER_MAX          = max_int(RECOVER_TICKS, DONE_TIMEOUT_TICKS);
  localparam int TW                 = max_int($clog2(TIMER_MAX + 1), 1);

  localparam logic [TW-1:0] RECOVER_LAST = TW'(RECOVER_TICKS - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DONE_TIMEOUT_TICKS - 1);
  localparam logic [2:0]    MAX_RETRY    = 3'(max_fast_retries);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_retry_cnt;
  logic          r_driver_enable;
  logic          r_reset_start;
  logic          r_slow_reset;
  logic          r_fault_active;
  logic          r_lockout;

  logic w_flt;
  logic w_confirmed;
  logic w_arm;
  logic w_next_slow;
  logic w_confirm_evt;

  assign w_arm       = (r_state == ST_DEBOUNCE);
  assign w_next_slow = (r_retry_cnt == MAX_RETRY);
  assign w_confirm_evt = (r_state == ST_DEBOUNCE) && enable_req && w_confirmed;

  fault_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_fault_debounce (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .fault_n  (fault_n),
    .arm      (w_arm),
    .flt      (w_flt),
    .confirmed(w_confirmed)
  );

  // slow_reset is held after the slow ISSUE and doubles as the "slow reset done" flag.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_timer         <= '0;
      r_retry_cnt     <= '0;
      r_driver_enable <= 1'b0;
      r_reset_start   <= 1'b0;
      r_slow_reset    <= 1'b0;
      r_fault_active  <= 1'b0;
      r_lockout       <= 1'b0;
    end else begin
      r_reset_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable_req) begin
            r_state         <= ST_RUN;
            r_driver_enable <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!enable_req) begin
            r_state         <= ST_IDLE;
            r_driver_enable <= 1'b0;
          end else if (!w_flt) begin
            r_state <= ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          if (!enable_req) begin
            r_state         <= ST_IDLE;
            r_driver_enable <= 1'b0;
          end else if (w_flt) begin
            r_state <= ST_RUN;
          end else if (w_confirmed) begin
            r_state        <= ST_ISSUE;
            r_reset_start  <= 1'b1;
            r_slow_reset   <= w_next_slow;
            r_fault_active <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (!r_slow_reset) begin
            r_retry_cnt <= r_retry_cnt + 3'd1;
          end
          r_state <= ST_WAIT_DONE;
          r_timer <= '0;
        end

        // A pending disable waits for the driver's reset to complete first.
        ST_WAIT_DONE: begin
          if (reset_done) begin
            r_timer <= '0;
            if (!enable_req) begin
              r_state         <= ST_IDLE;
              r_driver_enable <= 1'b0;
              r_fault_active  <= 1'b0;
              r_retry_cnt     <= '0;
              r_slow_reset    <= 1'b0;
            end else begin
              r_state <= ST_RECOVER;
            end
          end else if (r_timer == TIMEOUT_LAST) begin
            r_state         <= ST_LOCKOUT;
            r_driver_enable <= 1'b0;
            r_lockout       <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_RECOVER: begin
          if (!enable_req) begin
            r_state         <= ST_IDLE;
            r_driver_enable <= 1'b0;
            r_fault_active  <= 1'b0;
            r_retry_cnt     <= '0;
            r_slow_reset    <= 1'b0;
          end else if (r_timer == RECOVER_LAST) begin
            if (w_flt) begin
              r_state        <= ST_RUN;
              r_fault_active <= 1'b0;
              r_retry_cnt    <= '0;
              r_slow_reset   <= 1'b0;
            end else if (!r_slow_reset) begin
              r_state       <= ST_ISSUE;
              r_reset_start <= 1'b1;
              r_slow_reset  <= w_next_slow;
            end else begin
              r_state         <= ST_LOCKOUT;
              r_driver_enable <= 1'b0;
              r_lockout       <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_LOCKOUT: begin
          if (clear_fault && !enable_req) begin
            r_state        <= ST_IDLE;
            r_lockout      <= 1'b0;
            r_fault_active <= 1'b0;
            r_retry_cnt    <= '0;
            r_slow_reset   <= 1'b0;
          end
        end

        default: begin
          r_state         <= ST_IDLE;
          r_driver_enable <= 1'b0;
          r_lockout       <= 1'b0;
          r_fault_active  <= 1'b0;
          r_retry_cnt     <= '0;
          r_slow_reset    <= 1'b0;
        end
      endcase
    end
  end

  assign driver_enable = r_driver_enable;
  assign reset_start   = r_reset_start;
  assign slow_reset    = r_slow_reset;
  assign fault_active  = r_fault_active;
  assign lockout       = r_lockout;
  assign retry_cnt     = r_retry_cnt;

`ifdef GATE_DRIVER_FAULT_STATS_EN
  logic [15:0] r_fault_events;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fault_events <= '0;
    end else if (w_confirm_evt && (r_fault_events != 16'hFFFF)) begin
      r_fault_events <= r_fault_events + 16'd1;
    end
  end

  assign fault_events = r_fault_events;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_confirm_evt;
`endif

endmodule

// File: tb/tb_gate_driver_fault_monitor.sv
// Directed bench for gate_driver_fault_monitor; reset_start pulses are scored
// against an expected-slow_reset queue filled as each fault scenario is driven.
module tb_gate_driver_fault_monitor;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       fault_n;
  logic       enable_req;
  logic       clear_fault;
  logic       reset_done;
  logic       driver_enable;
  logic       reset_start;
  logic       slow_reset;
  logic       fault_active;
  logic       lockout;
  logic [2:0] retry_cnt;
`ifdef GATE_DRIVER_FAULT_STATS_EN
  logic [15:0] fault_events;
`endif

  int checks   = 0;
  int failures = 0;
  logic exp_slow_q[$];
  logic prev_start = 1'b0;

  gate_driver_fault_monitor dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .fault_n      (fault_n),
    .enable_req   (enable_req),
    .clear_fault  (clear_fault),
    .reset_done   (reset_done),
    .driver_enable(driver_enable),
    .reset_start  (reset_start),
    .slow_reset   (slow_reset),
    .fault_active (fault_active),
    .lockout      (lockout),
    .retry_cnt    (retry_cnt)
`ifdef GATE_DRIVER_FAULT_STATS_EN
    ,
    .fault_events (fault_events)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_pulse(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge sys_clk);
      n++;
      if (reset_start === 1'b1) break;
    end
    check("reset_start_within_bound", reset_start, 1'b1);
  endtask

  task automatic pulse_done();
    reset_done = 1'b1;
    tick(1);
    reset_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
  endtask

  // Scoreboard: every reset_start must match a queued expectation of slow_reset.
  always @(negedge sys_clk) begin
    if (reset_n === 1'b1 && reset_start === 1'b1) begin
      check("reset_start_not_back_to_back", prev_start, 1'b0);
      check("reset_start_expected", 16'(exp_slow_q.size() > 0), 16'd1);
      if (exp_slow_q.size() > 0) begin
        logic e;
        e = exp_slow_q.pop_front();
        $display("pulse: slow_reset=%0b expected=%0b retry_cnt=%0d", slow_reset, e, retry_cnt);
        check("slow_reset_at_pulse", slow_reset, e);
      end
    end
    prev_start = (reset_n === 1'b1) ? reset_start : 1'b0;
  end

  initial begin
    int n;
    int k;
    reset_n     = 1'b0;
    fault_n     = 1'b1;
    enable_req  = 1'b0;
    clear_fault = 1'b0;
    reset_done  = 1'b0;

    // Reset state
    tick(3);
    @(negedge sys_clk);
    check("rst_driver_enable", driver_enable, 1'b0);
    check("rst_reset_start", reset_start, 1'b0);
    check("rst_slow_reset", slow_reset, 1'b0);
    check("rst_fault_active", fault_active, 1'b0);
    check("rst_lockout", lockout, 1'b0);
    check("rst_retry_cnt", retry_cnt, 3'd0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // Enable: driver_enable follows one cycle later
    enable_req = 1'b1;
    @(negedge sys_clk);
    check("en_before_edge", driver_enable, 1'b0);
    @(negedge sys_clk);
    check("en_driver_enable", driver_enable, 1'b1);
    check("en_reset_start", reset_start, 1'b0);
    $display("step enable: driver_enable=%0b", driver_enable);
    tick(1);

    // Glitch shorter than the debounce window
    fault_n = 1'b0;
    tick(60);
    fault_n = 1'b1;
    tick(20);
    check("glitch_driver_enable", driver_enable, 1'b1);
    check("glitch_fault_active", fault_active, 1'b0);
    check("glitch_retry_cnt", retry_cnt, 3'd0);
    check("glitch_queue", 16'(exp_slow_q.size()), 16'd0);
    $display("step glitch: driver_enable=%0b fault_active=%0b", driver_enable, fault_active);

    // Single recoverable fault
    exp_slow_q.push_back(1'b0);
    fault_n = 1'b0;
    wait_pulse(300, n);
    tick(200 - n);
    fault_n = 1'b1;
    tick(270 - (200 - n));
    check("single_retry_cnt_1", retry_cnt, 3'd1);
    check("single_fault_active", fault_active, 1'b1);
    pulse_done();
    tick(2720);
    check("single_retry_cnt_0", retry_cnt, 3'd0);
    check("single_fault_cleared", fault_active, 1'b0);
    check("single_driver_enable", driver_enable, 1'b1);
    check("single_lockout", lockout, 1'b0);
    check("single_queue", 16'(exp_slow_q.size()), 16'd0);
    $display("step single: retry_cnt=%0d driver_enable=%0b", retry_cnt, driver_enable);

    // Permanent fault: three fast, one slow, then lockout
    exp_slow_q.push_back(1'b0);
    exp_slow_q.push_back(1'b0);
    exp_slow_q.push_back(1'b0);
    exp_slow_q.push_back(1'b1);
    fault_n = 1'b0;
    for (int p = 0; p < 4; p++) begin
      wait_pulse(3000, n);
      tick(20);
      pulse_done();
    end
    k = 0;
    while (k < 3000 && lockout !== 1'b1) begin
      @(negedge sys_clk);
      k++;
    end
    check("perm_lockout", lockout, 1'b1);
    check("perm_driver_enable", driver_enable, 1'b0);
    check("perm_fault_active", fault_active, 1'b1);
    check("perm_retry_cnt", retry_cnt, 3'd3);
    check("perm_queue", 16'(exp_slow_q.size()), 16'd0);
`ifdef GATE_DRIVER_FAULT_STATS_EN
    check("stats_two_faults", fault_events, 16'd2);
`endif
    $display("step permanent: lockout=%0b retry_cnt=%0d", lockout, retry_cnt);
    tick(1);
    pulse_clear();
    tick(3);
    check("clear_ignored_lockout", lockout, 1'b1);
    enable_req = 1'b0;
    fault_n = 1'b1;
    tick(2);
    pulse_clear();
    tick(2);
    check("clear_lockout", lockout, 1'b0);
    check("clear_driver_enable", driver_enable, 1'b0);
    check("clear_retry_cnt", retry_cnt, 3'd0);
    check("clear_fault_active", fault_active, 1'b0);
    $display("step clear: lockout=%0b driver_enable=%0b", lockout, driver_enable);

    // reset_done never arrives: timeout lockout 5400 cycles after WAIT_DONE entry
    enable_req = 1'b1;
    tick(3);
    exp_slow_q.push_back(1'b0);
    fault_n = 1'b0;
    wait_pulse(300, n);
    @(posedge sys_clk);
    k = 0;
    while (k < 6000) begin
      @(posedge sys_clk);
      #1;
      k++;
      if (lockout === 1'b1) break;
    end
    check("timeout_cycles", 16'(k), 16'd5400);
    check("timeout_lockout", lockout, 1'b1);
    check("timeout_driver_enable", driver_enable, 1'b0);
    $display("step timeout: lockout after %0d cycles", k);
    fault_n = 1'b1;
    enable_req = 1'b0;
    tick(2);
    pulse_clear();
    tick(2);
    check("timeout_cleared", lockout, 1'b0);

    // Asynchronous reset in the middle of WAIT_DONE
    enable_req = 1'b1;
    tick(3);
    exp_slow_q.push_back(1'b0);
    fault_n = 1'b0;
    wait_pulse(300, n);
    tick(10);
    check("midreset_pre_fault_active", fault_active, 1'b1);
    check("midreset_pre_driver_enable", driver_enable, 1'b1);
`ifdef GATE_DRIVER_FAULT_STATS_EN
    check("stats_four_faults", fault_events, 16'd4);
`endif
    reset_n = 1'b0;
    #2;
    check("midreset_driver_enable", driver_enable, 1'b0);
    check("midreset_reset_start", reset_start, 1'b0);
    check("midreset_slow_reset", slow_reset, 1'b0);
    check("midreset_fault_active", fault_active, 1'b0);
    check("midreset_lockout", lockout, 1'b0);
    check("midreset_retry_cnt", retry_cnt, 3'd0);
`ifdef GATE_DRIVER_FAULT_STATS_EN
    check("midreset_fault_events", fault_events, 16'd0);
`endif
    check("final_queue", 16'(exp_slow_q.size()), 16'd0);
    $display("step midreset: driver_enable=%0b fault_active=%0b", driver_enable, fault_active);
    fault_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
